// File: rtl/four_to_two_serial_encoder_pkg.sv
// four_to_two_enc_pkg: shared width constants and FSM state type for the serial encoder
package four_to_two_enc_pkg;
    localparam int ENC_N = 4;
    localparam int ENC_W = $clog2(ENC_N);
    typedef enum logic {IDLE, DRAIN} state_t;
endpackage

// File: rtl/four_to_two_serial_encoder_if.sv
// four_to_two_serial_encoder_if: request-in / index-out handshake bundle
interface four_to_two_serial_encoder_if #(parameter int N = four_to_two_enc_pkg::ENC_N);
    logic                 en;
    logic [N-1:0]         in_vec;
    logic                 in_valid;
    logic                 in_ready;
    logic [$clog2(N)-1:0] out_idx;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;
    logic                 err_zero;
    modport master (output en, in_vec, in_valid, out_ready,
                    input  in_ready, out_idx, out_valid, out_last, err_zero);
    modport slave  (input  en, in_vec, in_valid, out_ready,
                    output in_ready, out_idx, out_valid, out_last, err_zero);
endinterface

// File: rtl/four_to_two_serial_encoder_prio_enc_lsb.sv
// prio_enc_lsb: find-first-set from bit 0, plus the vector with that bit cleared and a last-bit flag
module prio_enc_lsb #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         last,
    output logic [N-1:0] rest
);
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (vec[i]) idx = W'(i);
        rest = vec & ~(N'(1) << idx);
        last = |vec && !(|rest);
    end
endmodule

// File: rtl/four_to_two_serial_encoder.sv
// four_to_two_serial_encoder: serialises every set bit of a request vector as a binary index, lowest first
module four_to_two_serial_encoder
    import four_to_two_enc_pkg::*;
(
    input logic clk,
    input logic rst,
    four_to_two_serial_encoder_if.slave bus
);
    state_t             state;
    logic [ENC_N-1:0]   pending;
    logic [ENC_N-1:0]   rest;
    logic [ENC_W-1:0]   idx;
    logic               last;
    prio_enc_lsb #(.N(ENC_N)) u_pe (.vec(pending), .idx(idx), .last(last), .rest(rest));
    // pending is only non-zero in DRAIN, so idx/last read 0 while idle
    assign bus.out_idx  = idx;
    assign bus.out_last = last;
    assign bus.in_ready = bus.en && state == IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            pending       <= '0;
            bus.out_valid <= 1'b0;
            bus.err_zero  <= 1'b0;
        end else begin
            bus.err_zero <= 1'b0;
            if (bus.en && state == IDLE && bus.in_valid) begin
                if (|bus.in_vec) begin
                    pending       <= bus.in_vec;
                    state         <= DRAIN;
                    bus.out_valid <= 1'b1;
                end else begin
                    bus.err_zero <= 1'b1;
                end
            end else if (bus.en && state == DRAIN && bus.out_ready) begin
                pending <= rest;
                if (last) begin
                    state         <= IDLE;
                    bus.out_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_four_to_two_serial_encoder.sv
// tb_four_to_two_serial_encoder: directed vectors checked against a queue-of-indices model plus literal pins
module tb_four_to_two_serial_encoder;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   q[$];
    logic merr = 1'b0;
    logic armed = 1'b0;
    four_to_two_serial_encoder_if #(.N(4)) bus();
    four_to_two_serial_encoder dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    // model: a vector becomes the ascending list of its set-bit positions
    always @(posedge clk) begin
        logic nerr;
        armed <= 1'b1;
        nerr = 1'b0;
        if (rst) q.delete();
        else if (bus.en) begin
            if (q.size() == 0 && bus.in_valid) begin
                if (bus.in_vec == 0) nerr = 1'b1;
                else for (int i = 0; i < 4; i++) if (bus.in_vec[i]) q.push_back(i);
            end else if (q.size() != 0 && bus.out_ready) void'(q.pop_front());
        end
        merr = nerr;
    end
    always @(negedge clk) begin
        if (armed) begin
            chk("out_valid", int'(bus.out_valid), int'(q.size() != 0));
            chk("in_ready", int'(bus.in_ready), int'(bus.en && q.size() == 0));
            chk("err_zero", int'(bus.err_zero), int'(merr));
            if (q.size() != 0) begin
                chk("out_idx", int'(bus.out_idx), q[0]);
                chk("out_last", int'(bus.out_last), int'(q.size() == 1));
            end
        end
    end
    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask
    task automatic beat(input string name, input int idx, input int last);
        chk({name, " valid"}, int'(bus.out_valid), 1);
        chk({name, " idx"}, int'(bus.out_idx), idx);
        chk({name, " last"}, int'(bus.out_last), last);
    endtask
    initial begin
        rst = 1'b1;
        bus.en = 1'b1;
        bus.in_vec = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        at_neg();
        at_neg();
        rst = 1'b0;
        at_neg();
        chk("rst out_valid", int'(bus.out_valid), 0);
        chk("rst err_zero", int'(bus.err_zero), 0);
        chk("rst in_ready", int'(bus.in_ready), 1);
        bus.in_vec = 4'b0100; bus.in_valid = 1'b1;
        at_neg();
        bus.in_valid = 1'b0;
        beat("v0100", 2, 1);
        at_neg();
        chk("v0100 done", int'(bus.out_valid), 0);
        bus.in_vec = 4'b1011; bus.in_valid = 1'b1;
        at_neg();
        bus.in_valid = 1'b0;
        beat("v1011 b0", 0, 0);
        at_neg();
        beat("v1011 b1", 1, 0);
        at_neg();
        beat("v1011 b2", 3, 1);
        at_neg();
        chk("v1011 done", int'(bus.out_valid), 0);
        bus.in_vec = 4'b1001; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        at_neg();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            beat("v1001 stall", 0, 0);
            if (i < 2) at_neg();
        end
        bus.out_ready = 1'b1;
        at_neg();
        beat("v1001 b1", 3, 1);
        at_neg();
        bus.in_vec = 4'b0000; bus.in_valid = 1'b1;
        at_neg();
        bus.in_valid = 1'b0;
        chk("zero err", int'(bus.err_zero), 1);
        chk("zero in_ready", int'(bus.in_ready), 1);
        at_neg();
        chk("zero err clear", int'(bus.err_zero), 0);
        bus.in_vec = 4'b0000; bus.in_valid = 1'b1;
        at_neg();
        bus.in_valid = 1'b0; bus.en = 1'b0;
        chk("zero err en0", int'(bus.err_zero), 1);
        at_neg();
        chk("zero err clear en0", int'(bus.err_zero), 0);
        bus.en = 1'b1;
        bus.in_vec = 4'b1111; bus.in_valid = 1'b1;
        at_neg();
        bus.in_valid = 1'b0;
        beat("v1111 b0", 0, 0);
        at_neg();
        beat("v1111 b1", 1, 0);
        at_neg();
        beat("v1111 b2", 2, 0);
        rst = 1'b1;
        at_neg();
        rst = 1'b0;
        chk("mid rst valid", int'(bus.out_valid), 0);
        chk("mid rst in_ready", int'(bus.in_ready), 1);
        at_neg();
        chk("post rst valid", int'(bus.out_valid), 0);
        bus.in_vec = 4'b1111; bus.in_valid = 1'b1;
        at_neg();
        bus.in_valid = 1'b0;
        beat("en b0", 0, 0);
        bus.en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            at_neg();
            beat("en0 frozen", 0, 0);
            chk("en0 in_ready", int'(bus.in_ready), 0);
        end
        bus.en = 1'b1;
        at_neg();
        beat("en b1", 1, 0);
        at_neg();
        beat("en b2", 2, 0);
        at_neg();
        beat("en b3", 3, 1);
        at_neg();
        chk("en done", int'(bus.out_valid), 0);
        at_neg();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
